serial_mem_loader: RTL and testbench

- Bit-serial command port that writes and reads back a small internal register array, the same shape as the team's word memories.
- It receives framed serial commands (write or read, address, data, parity) on one input line.
- A write commits a word to the array.
- A read serializes the addressed word back out on a separate line.
- It is the loading and readback end for testbench-driven memory initialization alongside the dff/udp/mux example cells.

---
 rtl/serial_mem_loader.sv | 264 ++++++++++++++++++++++++++
 tb/tb_serial_mem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mem_loader.sv
// -----------------------------------------------------------------------------
// serial_mem_loader
//
// Bit-serial command port for a small word memory. Framed commands arrive one
// bit per clock on sin while frame is high; writes commit a word into the
// array, reads stream the addressed word back out on sout, MSB first.
//
// Frame layout (all fields MSB first, one bit per cycle, frame=1 throughout):
//    write : CMD=1, ADDR[ADDR_W], DATA[WIDTH], PAR
//    read  : CMD=0, ADDR[ADDR_W], PAR
// Parity is even across every frame bit including PAR.
//
// Ports:
//    clock       rising-edge clock for all logic
//    clear       asynchronous active-low reset (FSM to IDLE, memory to 0)
//    sin         serial command bit, sampled while frame=1
//    frame       frame qualifier; dropping it in ADDR/DATA/PAR aborts
//    sout        serial read data, 0 whenever sout_valid=0
//    sout_valid  high on each cycle sout carries a read bit
//    busy        high whenever the FSM is not in IDLE
//    done        one-cycle pulse at the end of each completed command
//    err         error flag of the last completed command
//    dbg_addr    combinational peek address
//    dbg_data    mem[dbg_addr], or 0 when dbg_addr >= DEPTH
//
// state    | meaning
// ---------+------------------------------------------------------------------
// S_IDLE   | waiting; a frame=1 sample captures CMD and clears err
// S_ADDR   | shifting in ADDR_W address bits
// S_DATA   | shifting in WIDTH data bits (writes only)
// S_PAR    | sampling the parity bit
// S_COMMIT | check parity/address, perform write, pulse done unless a good read
// S_SHIFT  | WIDTH cycles of read data, then one done cycle with sout_valid=0
// -----------------------------------------------------------------------------
module serial_mem_loader #(
   parameter int WIDTH  = 3,
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clock,
   input  logic              clear,
   input  logic              sin,
   input  logic              frame,
   output logic              sout,
   output logic              sout_valid,
   output logic              busy,
   output logic              done,
   output logic              err,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [WIDTH-1:0]  dbg_data
);

   localparam int MAX_FIELD = (WIDTH > ADDR_W) ? WIDTH : ADDR_W;
   localparam int CNT_W     = $clog2(MAX_FIELD + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_PAR,
      S_COMMIT,
      S_SHIFT
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic [CNT_W-1:0]  cnt;
   logic              cmd_q;
   logic              par_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WIDTH-1:0]  data_q;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  mem [DEPTH];

   logic              addr_ok;
   logic              dbg_ok;
   logic              commit_ok;
   logic              cnt_zero;

   // Range checks only exist when the address space is larger than the array.
   generate
      if ((2 ** ADDR_W) > DEPTH) begin : g_range
         assign addr_ok = (int'(addr_q)   < DEPTH);
         assign dbg_ok  = (int'(dbg_addr) < DEPTH);
      end else begin : g_full
         assign addr_ok = 1'b1;
         assign dbg_ok  = 1'b1;
      end
   endgenerate

   // par_q holds the running XOR of every frame bit; even parity leaves it 0.
   assign commit_ok = !par_q && addr_ok;
   assign cnt_zero  = (cnt == '0);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and Moore-style outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx   = state;
      busy       = 1'b1;
      done       = 1'b0;
      sout_valid = 1'b0;
      sout       = 1'b0;
      err        = err_q;

      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (frame) begin
               state_nx = S_ADDR;
            end
         end

         S_ADDR: begin
            if (!frame) begin
               state_nx = S_IDLE;
            end else if (cnt_zero) begin
               state_nx = cmd_q ? S_DATA : S_PAR;
            end
         end

         S_DATA: begin
            if (!frame) begin
               state_nx = S_IDLE;
            end else if (cnt_zero) begin
               state_nx = S_PAR;
            end
         end

         S_PAR: begin
            state_nx = frame ? S_COMMIT : S_IDLE;
         end

         S_COMMIT: begin
            // err is presented in the same cycle as done so the pair can be
            // sampled together; err_q takes the same value at this edge.
            err = !commit_ok;
            if (cmd_q || !commit_ok) begin
               done     = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_SHIFT;
            end
         end

         S_SHIFT: begin
            if (cnt_zero) begin
               done     = 1'b1;
               state_nx = S_IDLE;
            end else begin
               sout_valid = 1'b1;
               sout       = shift_q[WIDTH-1];
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Frame datapath: field shift registers, running parity, bit down-counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         cnt     <= '0;
         cmd_q   <= 1'b0;
         par_q   <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         shift_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (frame) begin
                  cmd_q <= sin;
                  par_q <= sin;
                  err_q <= 1'b0;
                  cnt   <= CNT_W'(ADDR_W - 1);
               end
            end

            S_ADDR: begin
               if (frame) begin
                  addr_q <= {addr_q[ADDR_W-2:0], sin};
                  par_q  <= par_q ^ sin;
                  if (cnt_zero) begin
                     cnt <= CNT_W'(WIDTH - 1);
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end

            S_DATA: begin
               if (frame) begin
                  data_q <= {data_q[WIDTH-2:0], sin};
                  par_q  <= par_q ^ sin;
                  if (!cnt_zero) begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end

            S_PAR: begin
               if (frame) begin
                  par_q <= par_q ^ sin;
               end
            end

            S_COMMIT: begin
               err_q <= !commit_ok;
               if (!cmd_q && commit_ok) begin
                  // WIDTH data cycles plus the trailing done cycle at cnt==0.
                  shift_q <= mem[addr_q];
                  cnt     <= CNT_W'(WIDTH);
               end
            end

            S_SHIFT: begin
               if (!cnt_zero) begin
                  shift_q <= {shift_q[WIDTH-2:0], 1'b0};
                  cnt     <= cnt - CNT_W'(1);
               end
            end

            default: begin
               cnt <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Word array
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if ((state == S_COMMIT) && cmd_q && commit_ok) begin
         mem[addr_q] <= data_q;
      end
   end

   assign dbg_data = dbg_ok ? mem[dbg_addr] : '0;

endmodule

// File: tb/tb_serial_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_serial_mem_loader
//
// Drives framed serial commands into serial_mem_loader and compares the DUT's
// handshake, readout and memory contents against a word-level reference model
// (an array of expected words plus the expected err flag).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_mem_loader;

   localparam int WIDTH  = 3;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;

   logic              clock = 1'b0;
   logic              clear;
   logic              sin;
   logic              frame;
   logic              sout;
   logic              sout_valid;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] dbg_addr;
   logic [WIDTH-1:0]  dbg_data;

   int                n_checks = 0;
   int                n_fail   = 0;

   logic [WIDTH-1:0]  exp_mem [DEPTH];
   logic              exp_err;

   serial_mem_loader #(
      .WIDTH  (WIDTH),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clock      (clock),
      .clear      (clear),
      .sin        (sin),
      .frame      (frame),
      .sout       (sout),
      .sout_valid (sout_valid),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   // Peeks every address; stays inside the low clock phase (4 x 1 < 5).
   task automatic peek_all();
      for (int a = 0; a < DEPTH; a++) begin
         dbg_addr = a[ADDR_W-1:0];
         #1;
         check("dbg_data", 32'(dbg_data), 32'(exp_mem[a]));
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
      exp_err = 1'b0;
   endtask

   // Builds the bit list of a frame from its fields.
   task automatic build_frame(input bit is_wr, input logic [ADDR_W-1:0] addr,
                              input logic [WIDTH-1:0] data, input bit bad_par,
                              output logic bits [$]);
      int ones;
      bits = {};
      bits.push_back(is_wr);
      for (int i = ADDR_W - 1; i >= 0; i--) bits.push_back(addr[i]);
      if (is_wr) for (int i = WIDTH - 1; i >= 0; i--) bits.push_back(data[i]);
      ones = 0;
      foreach (bits[i]) ones += int'(bits[i]);
      bits.push_back(((ones % 2) == 1) ^ bad_par);
   endtask

   // One complete command. abort_at>0 drops frame after that many bits.
   task automatic run_cmd(input bit is_wr, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] data, input bit bad_par,
                          input int abort_at);
      logic bits [$];
      int   nsend;
      bit   ok;
      build_frame(is_wr, addr, data, bad_par, bits);
      nsend = (abort_at > 0) ? abort_at : bits.size();
      for (int i = 0; i < nsend; i++) begin
         @(negedge clock);
         frame = 1'b1;
         sin   = bits[i];
         check("done_in_frame", 32'(done), 0);
         check("sout_valid_in_frame", 32'(sout_valid), 0);
         if (i == 0) begin
            check("busy_idle", 32'(busy), 0);
            check("err_held", 32'(err), 32'(exp_err));
            peek_all();
         end else begin
            check("busy_frame", 32'(busy), 1);
            check("err_cleared", 32'(err), 0);
         end
      end
      exp_err = 1'b0;

      if (abort_at > 0) begin
         @(negedge clock);
         frame = 1'b0;
         sin   = 1'($urandom);
         check("abort_busy", 32'(busy), 1);
         check("abort_done", 32'(done), 0);
         @(negedge clock);
         check("abort_idle", 32'(busy), 0);
         check("abort_no_done", 32'(done), 0);
         check("abort_err", 32'(err), 0);
         return;
      end

      ok = !bad_par;
      // COMMIT cycle; frame is ignored here during a good read.
      @(negedge clock);
      frame = (!is_wr && ok) ? 1'($urandom) : 1'b0;
      sin   = 1'($urandom);
      check("commit_done", 32'(done), (is_wr || !ok) ? 1 : 0);
      check("commit_busy", 32'(busy), 1);
      check("commit_err", 32'(err), ok ? 0 : 1);
      check("commit_sout_valid", 32'(sout_valid), 0);

      if (!ok) begin
         exp_err = 1'b1;
      end else if (is_wr) begin
         exp_mem[addr] = data;
      end else begin
         for (int b = WIDTH - 1; b >= 0; b--) begin
            @(negedge clock);
            frame = 1'($urandom);
            sin   = 1'($urandom);
            check("shift_valid", 32'(sout_valid), 1);
            check("shift_sout", 32'(sout), 32'(exp_mem[addr][b]));
            check("shift_done", 32'(done), 0);
         end
         @(negedge clock);
         frame = 1'b0;
         check("read_done", 32'(done), 1);
         check("read_valid_low", 32'(sout_valid), 0);
         check("read_sout_low", 32'(sout), 0);
         check("read_err", 32'(err), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic bits [$];
      int   kind;
      bit   wr;
      int   n;

      clear    = 1'b0;
      frame    = 1'b0;
      sin      = 1'b0;
      dbg_addr = '0;
      model_reset();

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);
      check("rst_done", 32'(done), 0);
      check("rst_sout", 32'(sout), 0);
      check("rst_sout_valid", 32'(sout_valid), 0);
      peek_all();
      @(negedge clock);
      clear = 1'b1;

      // Directed cases
      run_cmd(1'b1, 2'd2, 3'b101, 1'b0, 0);   // 1,1,0,1,0,1,0
      run_cmd(1'b0, 2'd2, 3'b000, 1'b0, 0);   // 0,1,0,1 -> sout 1,0,1
      run_cmd(1'b1, 2'd1, 3'b111, 1'b1, 0);   // bad parity
      run_cmd(1'b1, 2'd3, 3'b011, 1'b0, 5);   // abort after 2nd DATA bit
      run_cmd(1'b1, 2'd3, 3'b011, 1'b0, 0);
      run_cmd(1'b0, 2'd3, 3'b000, 1'b0, 0);
      run_cmd(1'b0, 2'd0, 3'b000, 1'b1, 0);   // read with bad parity

      // Randomized traffic
      for (int t = 0; t < 120; t++) begin
         kind = $urandom_range(0, 9);
         wr   = (kind <= 3) ? 1'b1 : (kind <= 6) ? 1'b0 : 1'($urandom);
         n    = wr ? (2 + ADDR_W + WIDTH) : (2 + ADDR_W);
         run_cmd(wr, ADDR_W'($urandom), WIDTH'($urandom), (kind == 7),
                 (kind >= 8) ? $urandom_range(1, n - 1) : 0);
      end
      peek_all();

      // Async reset in the middle of a readout
      run_cmd(1'b1, 2'd1, 3'b110, 1'b0, 0);
      build_frame(1'b0, 2'd1, 3'b000, 1'b0, bits);
      foreach (bits[i]) begin
         @(negedge clock);
         frame = 1'b1;
         sin   = bits[i];
      end
      @(negedge clock);             // COMMIT
      frame = 1'b0;
      @(negedge clock);             // first SHIFT bit
      check("pre_rst_valid", 32'(sout_valid), 1);
      check("pre_rst_sout", 32'(sout), 1);
      #2;
      clear = 1'b0;
      #1;
      check("mid_rst_sout", 32'(sout), 0);
      check("mid_rst_valid", 32'(sout_valid), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_done", 32'(done), 0);
      model_reset();
      @(negedge clock);
      peek_all();
      @(negedge clock);
      clear = 1'b1;
      run_cmd(1'b0, 2'd1, 3'b000, 1'b0, 0);
      run_cmd(1'b1, 2'd0, 3'b010, 1'b0, 0);
      run_cmd(1'b0, 2'd0, 3'b000, 1'b0, 0);
      @(negedge clock);
      peek_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
